// File: rtl/fan_demux_hs.sv
// 1-to-NUM_OUT registered demultiplexer with a valid/ready handshake per channel.
// Optional FAN_BROADCAST_EN adds a bcast input that loads every channel at once.
module fan_demux_hs #(
    parameter int SIGNAL_WIDTH = 8,
    parameter int NUM_OUT      = 8,
    parameter int SEL_WIDTH    = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SIGNAL_WIDTH-1:0]         in_data,
    input  logic [SEL_WIDTH-1:0]            in_sel,
    input  logic                            in_valid,
`ifdef FAN_BROADCAST_EN
    input  logic                            bcast,
`endif
    output logic                            in_ready,
    output logic [NUM_OUT*SIGNAL_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]              out_valid,
    input  logic [NUM_OUT-1:0]              out_ready,
    output logic                            err_sel
);

    localparam logic [SEL_WIDTH:0] NUM_OUT_W = (SEL_WIDTH+1)'(NUM_OUT);

    logic [NUM_OUT*SIGNAL_WIDTH-1:0] out_data_q, out_data_d;
    logic [NUM_OUT-1:0]              out_valid_q, out_valid_d;
    logic                            err_sel_q, err_sel_d;

    logic               bcast_w;
    logic               sel_ok;
    logic               accept;
    logic               sel_blocked;
    logic [NUM_OUT-1:0] blocked;
    logic [NUM_OUT-1:0] sel_hit;
    logic [NUM_OUT-1:0] load;

`ifdef FAN_BROADCAST_EN
    assign bcast_w = bcast;
`else
    assign bcast_w = 1'b0;
`endif

    always_comb begin
        sel_ok      = ({1'b0, in_sel} < NUM_OUT_W);
        blocked     = out_valid_q & ~out_ready;
        sel_hit     = '0;
        sel_blocked = 1'b0;
        for (int c = 0; c < NUM_OUT; c++) begin
            sel_hit[c] = (in_sel == SEL_WIDTH'(c));
        end
        sel_blocked = |(sel_hit & blocked);

        // A broadcast needs every channel free; an out-of-range select is always taken.
        if (bcast_w) begin
            in_ready = ~|blocked;
        end else begin
            in_ready = ~sel_ok | ~sel_blocked;
        end

        accept = in_valid & in_ready;
        load   = accept ? (bcast_w ? '1 : sel_hit) : '0;

        out_valid_d = load | (out_valid_q & ~out_ready);
        out_data_d  = out_data_q;
        for (int c = 0; c < NUM_OUT; c++) begin
            if (load[c]) begin
                out_data_d[c*SIGNAL_WIDTH +: SIGNAL_WIDTH] = in_data;
            end
        end
        err_sel_d = accept & ~bcast_w & ~sel_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
            err_sel_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_sel_q   <= err_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err_sel   = err_sel_q;

endmodule
